// File: rtl/usb3_ep0_host_if.sv
// EP0 host-side bridge: SETUP words into the endpoint IN buffer, response out of the OUT buffer as TX packets.
// Latency: one word per RD_LAT+2 cycles on TX; SETUP words are written in the cycle they arrive.
// Backpressure: setup_busy outside the two SETUP word states; tx_req/tx_valid held until tx_ack/tx_ready.
module usb3_ep0_host_if #(
   parameter int MAX_PKT     = 512,
   parameter int RD_LAT      = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        local_clk,
   input  logic        reset_n,
   input  logic        setup_valid,
   input  logic [31:0] setup_data,
   output logic        setup_busy,
   output logic [8:0]  ep_in_addr,
   output logic [31:0] ep_in_data,
   output logic        ep_in_wren,
   input  logic        ep_in_ready,
   output logic        ep_in_commit,
   output logic [10:0] ep_in_commit_len,
   input  logic        ep_in_commit_ack,
   output logic [8:0]  ep_out_addr,
   input  logic [31:0] ep_out_q,
   input  logic [10:0] ep_out_len,
   input  logic        ep_out_hasdata,
   output logic        ep_out_arm,
   input  logic        ep_out_arm_ack,
   output logic        tx_req,
   output logic [10:0] tx_len,
   input  logic        tx_ack,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic        err_timeout
);

   localparam int WW = $clog2(MAX_PKT / 4 + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int RW = $clog2(RD_LAT + 1);

   typedef enum logic [3:0] {
      ST_RESET, ST_IDLE, ST_SETUP_1, ST_WAIT_RDY, ST_COMMIT, ST_COMMIT_DROP,
      ST_WAIT_DATA, ST_TX_REQ, ST_RD_WAIT, ST_TX_BEAT, ST_ARM, ST_ARM_DROP
   } state_t;

   state_t         state, state_nxt;
   logic [10:0]    remaining;
   logic [8:0]     word_addr;
   logic [WW-1:0]  beat_idx;
   logic [WW-1:0]  pkt_words;
   logic [31:0]    hold_q;
   logic [TW-1:0]  tmo_cnt;
   logic [RW-1:0]  rd_cnt;
   logic           err_q;

   logic [10:0]    pkt_len_c;
   logic [11:0]    pkt_round_c;
   logic [WW-1:0]  pkt_words_c;
   logic [10:0]    dec_c;
   logic           last_beat;
   logic           rd_done;
   logic           in_hs;
   logic           tmo_hit;
   logic           tmo_fire;

   assign pkt_len_c   = (remaining > 11'(MAX_PKT)) ? 11'(MAX_PKT) : remaining;
   assign pkt_round_c = {1'b0, pkt_len_c} + 12'd3;
   assign pkt_words_c = WW'(pkt_round_c >> 2);
   assign dec_c       = (remaining >= 11'd4) ? 11'd4 : remaining;
   assign last_beat   = (beat_idx == pkt_words - WW'(1));
   assign rd_done     = (rd_cnt == RW'(RD_LAT));
   assign in_hs       = (state == ST_COMMIT) || (state == ST_COMMIT_DROP) ||
                        (state == ST_ARM) || (state == ST_ARM_DROP);
   assign tmo_hit     = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

   // An acknowledge edge arriving on the final count still wins over the timeout.
   assign tmo_fire = tmo_hit &&
                     (((state == ST_COMMIT)      && !ep_in_commit_ack) ||
                      ((state == ST_COMMIT_DROP) &&  ep_in_commit_ack) ||
                      ((state == ST_ARM)         && !ep_out_arm_ack)   ||
                      ((state == ST_ARM_DROP)    &&  ep_out_arm_ack));

   always_ff @(posedge local_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_RESET;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET:       state_nxt = ST_IDLE;
         ST_IDLE:        if (setup_valid) state_nxt = ST_SETUP_1;
         ST_SETUP_1:     if (setup_valid) state_nxt = ST_WAIT_RDY;
         ST_WAIT_RDY:    if (ep_in_ready) state_nxt = ST_COMMIT;
         ST_COMMIT:      if (ep_in_commit_ack) state_nxt = ST_COMMIT_DROP;
                         else if (tmo_fire) state_nxt = ST_IDLE;
         ST_COMMIT_DROP: if (!ep_in_commit_ack) state_nxt = ST_WAIT_DATA;
                         else if (tmo_fire) state_nxt = ST_IDLE;
         ST_WAIT_DATA:   if (ep_out_hasdata) state_nxt = ST_TX_REQ;
         ST_TX_REQ:      if (tx_ack) state_nxt = (pkt_len_c == 11'd0) ? ST_ARM : ST_RD_WAIT;
         ST_RD_WAIT:     if (rd_done) state_nxt = ST_TX_BEAT;
         ST_TX_BEAT: begin
            if (tx_ready) begin
               if (!last_beat)             state_nxt = ST_RD_WAIT;
               else if (remaining > dec_c) state_nxt = ST_TX_REQ;
               else                        state_nxt = ST_ARM;
            end
         end
         ST_ARM:         if (ep_out_arm_ack) state_nxt = ST_ARM_DROP;
                         else if (tmo_fire) state_nxt = ST_IDLE;
         ST_ARM_DROP:    if (!ep_out_arm_ack || tmo_fire) state_nxt = ST_IDLE;
         default:        state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      setup_busy       = 1'b1;
      ep_in_addr       = 9'd0;
      ep_in_data       = 32'd0;
      ep_in_wren       = 1'b0;
      ep_in_commit     = 1'b0;
      ep_in_commit_len = 11'd0;
      ep_out_arm       = 1'b0;
      tx_req           = 1'b0;
      tx_len           = 11'd0;
      tx_valid         = 1'b0;
      tx_data          = 32'd0;
      tx_last          = 1'b0;
      case (state)
         ST_IDLE: begin
            setup_busy = 1'b0;
            ep_in_wren = setup_valid;
            ep_in_data = setup_valid ? setup_data : 32'd0;
         end
         ST_SETUP_1: begin
            setup_busy = 1'b0;
            ep_in_addr = 9'd1;
            ep_in_wren = setup_valid;
            ep_in_data = setup_valid ? setup_data : 32'd0;
         end
         ST_COMMIT: begin
            ep_in_commit     = 1'b1;
            ep_in_commit_len = 11'd8;
         end
         ST_TX_REQ: begin
            tx_req = 1'b1;
            tx_len = pkt_len_c;
         end
         ST_TX_BEAT: begin
            tx_valid = 1'b1;
            tx_data  = hold_q;
            tx_last  = last_beat;
         end
         ST_ARM:  ep_out_arm = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge local_clk or negedge reset_n) begin
      if (!reset_n) begin
         remaining <= '0;
         word_addr <= '0;
         beat_idx  <= '0;
         pkt_words <= '0;
         hold_q    <= '0;
         tmo_cnt   <= '0;
         rd_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt <= in_hs ? tmo_cnt + TW'(1) : '0;
         rd_cnt  <= ((state == ST_RD_WAIT) && !rd_done) ? rd_cnt + RW'(1) : '0;
         if (tmo_fire) err_q <= 1'b1;
         case (state)
            ST_WAIT_DATA: if (ep_out_hasdata) begin
               remaining <= ep_out_len;
               word_addr <= '0;
            end
            ST_TX_REQ: if (tx_ack) begin
               pkt_words <= pkt_words_c;
               beat_idx  <= '0;
            end
            ST_RD_WAIT: if (rd_done) hold_q <= ep_out_q;
            ST_TX_BEAT: if (tx_ready) begin
               word_addr <= word_addr + 9'd1;
               remaining <= remaining - dec_c;
               beat_idx  <= beat_idx + WW'(1);
            end
            default: ;
         endcase
      end
   end

   assign ep_out_addr = word_addr;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_usb3_ep0_host_if.sv
// Directed bench for usb3_ep0_host_if with a simple endpoint, ROM-backed OUT buffer and TX sink.
module tb_usb3_ep0_host_if;

   logic        local_clk = 1'b0;
   logic        reset_n;
   logic        setup_valid;
   logic [31:0] setup_data;
   logic        setup_busy;
   logic [8:0]  ep_in_addr;
   logic [31:0] ep_in_data;
   logic        ep_in_wren;
   logic        ep_in_ready;
   logic        ep_in_commit;
   logic [10:0] ep_in_commit_len;
   logic        ep_in_commit_ack;
   logic [8:0]  ep_out_addr;
   logic [31:0] ep_out_q;
   logic [10:0] ep_out_len;
   logic        ep_out_hasdata;
   logic        ep_out_arm;
   logic        ep_out_arm_ack;
   logic        tx_req;
   logic [10:0] tx_len;
   logic        tx_ack;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_last;
   logic        tx_ready;
   logic        err_timeout;

   usb3_ep0_host_if dut (
      .local_clk(local_clk), .reset_n(reset_n),
      .setup_valid(setup_valid), .setup_data(setup_data), .setup_busy(setup_busy),
      .ep_in_addr(ep_in_addr), .ep_in_data(ep_in_data), .ep_in_wren(ep_in_wren),
      .ep_in_ready(ep_in_ready), .ep_in_commit(ep_in_commit),
      .ep_in_commit_len(ep_in_commit_len), .ep_in_commit_ack(ep_in_commit_ack),
      .ep_out_addr(ep_out_addr), .ep_out_q(ep_out_q), .ep_out_len(ep_out_len),
      .ep_out_hasdata(ep_out_hasdata), .ep_out_arm(ep_out_arm), .ep_out_arm_ack(ep_out_arm_ack),
      .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready), .err_timeout(err_timeout)
   );

   always #5 local_clk = ~local_clk;

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] rom_word(input logic [8:0] a);
      return {7'h55, a, 7'h2A, a};
   endfunction

   // OUT buffer: two-stage read pipeline, q follows the address RD_LAT=2 cycles later.
   logic [31:0] rd_p0, rd_p1;
   always @(posedge local_clk) begin
      rd_p0 <= rom_word(ep_out_addr);
      rd_p1 <= rd_p0;
   end
   assign ep_out_q = rd_p1;

   // Endpoint handshake responders: acknowledge follows the request level three cycles later.
   logic       c_en = 1'b1;
   logic [2:0] c_sr = 3'b000;
   logic [2:0] a_sr = 3'b000;
   int         ack_dly = 0;
   logic       bp_mode = 1'b0;

   initial begin
      ep_in_commit_ack = 1'b0;
      forever begin
         @(posedge local_clk); #1;
         c_sr = {c_sr[1:0], ep_in_commit};
         ep_in_commit_ack = c_en & c_sr[2];
      end
   end

   initial begin
      ep_out_arm_ack = 1'b0;
      forever begin
         @(posedge local_clk); #1;
         a_sr = {a_sr[1:0], ep_out_arm};
         ep_out_arm_ack = a_sr[2];
      end
   end

   initial begin
      tx_ack = 1'b0;
      forever begin
         @(posedge local_clk); #1;
         if (tx_req) begin
            for (int k = 0; k < ack_dly; k++) begin
               @(posedge local_clk); #1;
            end
            tx_ack = 1'b1;
            @(posedge local_clk); #1;
            tx_ack = 1'b0;
         end
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge local_clk); #1;
         tx_ready = bp_mode ? ~tx_ready : 1'b1;
      end
   end

   // Observation state, filled only by the main initial process.
   logic [8:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [10:0] txlen_q[$];
   logic [31:0] beat_d[$];
   logic [8:0]  beat_a[$];
   int          last_q[$];
   int          commit_cnt, arm_cnt, valid_cyc;
   logic [10:0] commit_len_s;
   logic        commit_d, arm_d, busy_s, commit_s, tx_valid_s;
   logic        drop_hd = 1'b0;

   task automatic clear_obs();
      wr_addr_q = {}; wr_data_q = {}; txlen_q = {};
      beat_d = {}; beat_a = {}; last_q = {};
      commit_cnt = 0; arm_cnt = 0; valid_cyc = 0; commit_len_s = '0;
   endtask

   task automatic step();
      @(negedge local_clk);
      busy_s = setup_busy;
      commit_s = ep_in_commit;
      tx_valid_s = tx_valid;
      if (ep_in_wren) begin
         wr_addr_q.push_back(ep_in_addr);
         wr_data_q.push_back(ep_in_data);
      end
      if (ep_in_commit && !commit_d) begin
         commit_cnt++;
         commit_len_s = ep_in_commit_len;
      end
      commit_d = ep_in_commit;
      if (ep_out_arm && !arm_d) arm_cnt++;
      arm_d = ep_out_arm;
      if (tx_req && tx_ack) txlen_q.push_back(tx_len);
      if (tx_valid) valid_cyc++;
      if (tx_valid && tx_ready) begin
         beat_d.push_back(tx_data);
         beat_a.push_back(ep_out_addr);
         if (tx_last) last_q.push_back(beat_d.size() - 1);
      end
      @(posedge local_clk); #1;
   endtask

   // SETUP words with a one-cycle gap between them.
   task automatic do_setup(input logic [31:0] w0, input logic [31:0] w1);
      setup_valid = 1'b1; setup_data = w0;
      step();
      setup_valid = 1'b0; setup_data = 32'hDEAD_BEEF;
      step();
      setup_valid = 1'b1; setup_data = w1;
      step();
      setup_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (drop_hd && txlen_q.size() > 0) begin
            ep_out_hasdata = 1'b0;
            ep_out_len = 11'd3;
         end
         if (!busy_s) begin
            ok = 1'b1;
            break;
         end
      end
      ep_out_hasdata = 1'b0;
   endtask

   task automatic run_xfer(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [10:0] len, input int budget, output bit ok);
      clear_obs();
      do_setup(w0, w1);
      ep_out_len = len;
      ep_out_hasdata = 1'b1;
      wait_idle(budget, ok);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      tests++;
      if (setup_busy !== 1'b1) begin
         fails++; $display("FAIL reset_busy: got %0b want 1", setup_busy);
      end
      tests++;
      if ({tx_req, tx_valid, tx_last, ep_in_commit, ep_out_arm, ep_in_wren, err_timeout} !== 7'd0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {tx_req, tx_valid, tx_last, ep_in_commit, ep_out_arm, ep_in_wren, err_timeout});
      end
      tests++;
      if ({ep_out_addr, ep_in_addr, tx_len, ep_in_commit_len, tx_data, ep_in_data} !== '0) begin
         fails++; $display("FAIL reset_buses: got nonzero, addr=%0d len=%0d", ep_out_addr, tx_len);
      end
      @(posedge local_clk); #1;
      reset_n = 1'b1;
      #1;
      tests++;
      if (setup_busy !== 1'b1) begin
         fails++; $display("FAIL release_busy: got %0b want 1", setup_busy);
      end
      @(posedge local_clk); #1;
      tests++;
      if (setup_busy !== 1'b0) begin
         fails++; $display("FAIL idle_busy: got %0b want 0", setup_busy);
      end
   endtask

   task automatic test_get_descriptor();
      bit ok;
      int bad = 0;
      run_xfer(32'h8006_0001, 32'h0000_1200, 11'd18, 400, ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL gd_done: got busy=%0b want idle", busy_s);
      end
      tests++;
      if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 9'd0 || wr_addr_q[1] !== 9'd1 ||
          wr_data_q[0] !== 32'h8006_0001 || wr_data_q[1] !== 32'h0000_1200) begin
         fails++; $display("FAIL gd_setup_wr: got %0d writes want 2 (addr0=0 addr1=1)", wr_addr_q.size());
      end
      tests++;
      if (commit_cnt != 1 || commit_len_s !== 11'd8) begin
         fails++; $display("FAIL gd_commit: got cnt=%0d len=%0d want 1/8", commit_cnt, commit_len_s);
      end
      tests++;
      if (txlen_q.size() != 1 || txlen_q[0] !== 11'd18) begin
         fails++; $display("FAIL gd_txlen: got n=%0d len=%0d want 1/18", txlen_q.size(), txlen_q[0]);
      end
      tests++;
      if (beat_d.size() != 5 || last_q.size() != 1 || last_q[0] != 4) begin
         fails++; $display("FAIL gd_beats: got %0d beats, %0d lasts want 5 beats last on 5", beat_d.size(), last_q.size());
      end
      foreach (beat_d[i]) if (beat_d[i] !== rom_word(9'(i)) || beat_a[i] !== 9'(i)) bad++;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL gd_data: got %0d bad words want 0", bad);
      end
      tests++;
      if (arm_cnt != 1 || err_timeout !== 1'b0) begin
         fails++; $display("FAIL gd_arm: got arms=%0d err=%0b want 1/0", arm_cnt, err_timeout);
      end
   endtask

   task automatic test_set_address();
      bit ok;
      run_xfer(32'h0005_0500, 32'h0000_0000, 11'd0, 200, ok);
      tests++;
      if (!ok || setup_busy !== 1'b0) begin
         fails++; $display("FAIL sa_done: got busy=%0b want 0", setup_busy);
      end
      tests++;
      if (txlen_q.size() != 1 || txlen_q[0] !== 11'd0) begin
         fails++; $display("FAIL sa_txlen: got n=%0d len=%0d want 1/0", txlen_q.size(), txlen_q[0]);
      end
      tests++;
      if (valid_cyc != 0) begin
         fails++; $display("FAIL sa_novalid: got %0d valid cycles want 0", valid_cyc);
      end
      tests++;
      if (arm_cnt != 1) begin
         fails++; $display("FAIL sa_arm: got %0d arms want 1", arm_cnt);
      end
   endtask

   task automatic test_multi_packet();
      bit ok;
      int bad = 0;
      drop_hd = 1'b1;
      run_xfer(32'h8006_0002, 32'h0000_0406, 11'd1030, 5000, ok);
      drop_hd = 1'b0;
      tests++;
      if (!ok) begin
         fails++; $display("FAIL mp_done: got busy=%0b want idle", busy_s);
      end
      tests++;
      if (txlen_q.size() != 3 || txlen_q[0] !== 11'd512 || txlen_q[1] !== 11'd512 || txlen_q[2] !== 11'd6) begin
         fails++;
         $display("FAIL mp_txlen: got n=%0d %0d,%0d,%0d want 512,512,6",
                  txlen_q.size(), txlen_q[0], txlen_q[1], txlen_q[2]);
      end
      tests++;
      if (beat_d.size() != 258) begin
         fails++; $display("FAIL mp_beats: got %0d want 258", beat_d.size());
      end
      tests++;
      if (last_q.size() != 3 || last_q[0] != 127 || last_q[1] != 255 || last_q[2] != 257) begin
         fails++; $display("FAIL mp_last: got n=%0d first=%0d want beats 128,256,258", last_q.size(), last_q[0] + 1);
      end
      foreach (beat_d[i]) if (beat_d[i] !== rom_word(9'(i)) || beat_a[i] !== 9'(i)) bad++;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL mp_addr_data: got %0d bad words want 0", bad);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad = 0;
      bp_mode = 1'b1;
      ack_dly = 10;
      run_xfer(32'h8006_0003, 32'h0000_0258, 11'd600, 5000, ok);
      bp_mode = 1'b0;
      ack_dly = 0;
      tests++;
      if (!ok || txlen_q.size() != 2 || txlen_q[0] !== 11'd512 || txlen_q[1] !== 11'd88) begin
         fails++; $display("FAIL bp_txlen: got ok=%0b n=%0d want 512,88", ok, txlen_q.size());
      end
      tests++;
      if (beat_d.size() != 150 || last_q.size() != 2 || last_q[0] != 127 || last_q[1] != 149) begin
         fails++; $display("FAIL bp_beats: got %0d beats %0d lasts want 150/2", beat_d.size(), last_q.size());
      end
      foreach (beat_d[i]) if (beat_d[i] !== rom_word(9'(i))) bad++;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL bp_data: got %0d bad words want 0", bad);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int hi = 0;
      c_en = 1'b0;
      clear_obs();
      do_setup(32'h8006_0004, 32'h0000_0012);
      for (int i = 0; i < 600; i++) begin
         step();
         if (commit_s) hi++;
         if (hi > 0 && !commit_s) break;
      end
      tests++;
      if (hi != 255) begin
         fails++; $display("FAIL to_len: got commit high %0d cycles want 255", hi);
      end
      tests++;
      if (err_timeout !== 1'b1 || ep_in_commit !== 1'b0 || setup_busy !== 1'b0) begin
         fails++;
         $display("FAIL to_state: got err=%0b commit=%0b busy=%0b want 1/0/0",
                  err_timeout, ep_in_commit, setup_busy);
      end
      c_en = 1'b1;
      run_xfer(32'h8006_0001, 32'h0000_0008, 11'd8, 400, ok);
      tests++;
      if (!ok || beat_d.size() != 2 || err_timeout !== 1'b1) begin
         fails++; $display("FAIL to_recover: got ok=%0b beats=%0d err=%0b want 1/2/1", ok, beat_d.size(), err_timeout);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      bit seen = 1'b0;
      int bad = 0;
      clear_obs();
      do_setup(32'h8006_0001, 32'h0000_0028);
      ep_out_len = 11'd40;
      ep_out_hasdata = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge local_clk);
         if (tx_valid) begin
            seen = 1'b1;
            break;
         end
      end
      tests++;
      if (!seen) begin
         fails++; $display("FAIL ar_reach_beat: got no tx_valid within 200 cycles want beat");
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({tx_valid, tx_req, ep_out_arm, ep_in_commit} !== 4'b0000 || setup_busy !== 1'b1) begin
         fails++;
         $display("FAIL ar_drop: got valid/req/arm/commit=%b busy=%0b want 0000/1",
                  {tx_valid, tx_req, ep_out_arm, ep_in_commit}, setup_busy);
      end
      ep_out_hasdata = 1'b0;
      commit_d = 1'b0;
      arm_d = 1'b0;
      repeat (3) @(posedge local_clk);
      #1;
      reset_n = 1'b1;
      @(posedge local_clk); #1;
      tests++;
      if (setup_busy !== 1'b0) begin
         fails++; $display("FAIL ar_idle: got busy=%0b want 0", setup_busy);
      end
      run_xfer(32'h8006_0001, 32'h0000_1200, 11'd18, 400, ok);
      foreach (beat_d[i]) if (beat_d[i] !== rom_word(9'(i))) bad++;
      tests++;
      if (!ok || beat_d.size() != 5 || bad != 0 || arm_cnt != 1) begin
         fails++; $display("FAIL ar_after: got ok=%0b beats=%0d bad=%0d arms=%0d want 1/5/0/1", ok, beat_d.size(), bad, arm_cnt);
      end
   endtask

   initial begin
      setup_valid = 1'b0;
      setup_data = '0;
      ep_in_ready = 1'b1;
      ep_out_len = '0;
      ep_out_hasdata = 1'b0;
      commit_d = 1'b0;
      arm_d = 1'b0;
      busy_s = 1'b1;
      commit_s = 1'b0;
      tx_valid_s = 1'b0;
      clear_obs();
      test_reset();
      test_get_descriptor();
      test_set_address();
      test_multi_packet();
      test_backpressure();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
